// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate-format tag and parameter helpers for the
// immediate-generation stage.
package imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_t;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder: raw instruction -> sign-extended immediate
// and format tag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RV64 = 1'b0
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt
);

  logic [31:0] imm32;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    imm32 = '0;
    fmt   = FMT_NONE;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_IMM_32: begin
        if (RV64) begin
          fmt   = FMT_I;
          imm32 = {{20{inst[31]}}, inst[31:20]};
        end
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {inst[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Every format's sign bit is inst[31], which is bit 31 of imm32.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with valid/ready handshake and an
// optional skid entry so in_ready does not depend combinationally on out_ready.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit RV64 = 1'b0,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  entry_t          in_entry;
  entry_t          main_q, main_d, skid_q, skid_d;
  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            in_fire, main_free;

  imm_decode #(.XLEN(XLEN), .RV64(RV64)) u_decode (
    .inst (in_inst),
    .imm  (dec_imm),
    .fmt  (dec_fmt)
  );

  assign in_entry  = '{imm: dec_imm, fmt: dec_fmt, pc: in_pc};
  assign in_ready  = SKID ? !skid_valid_q : (!main_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready && !flush;
  assign main_free = !main_valid_q || out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      // The older skid entry always refills main first to keep FIFO order.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) skid_d = in_entry;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) main_d = in_entry;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_d       = in_entry;
    end
    if (!SKID) skid_valid_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments only; the next-state
  // values are all computed in the always_comb block above.
  // NOTE: payload registers are reset too, because out_imm/out_pc/out_fmt
  // must read as zero / FMT_NONE straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '{imm: '0, fmt: FMT_NONE, pc: '0};
      skid_q       <= '{imm: '0, fmt: FMT_NONE, pc: '0};
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_imm   = main_q.imm;
  assign out_fmt   = main_q.fmt;
  assign out_pc    = main_q.pc;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: a 32-bit (RV64=0) and a 64-bit (RV64=1) instance
// share one stimulus stream and are checked against a FIFO reference model.
module tb_imm_gen_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        rdy32, v32, rdy64, v64;
  logic [31:0] imm32, pc32;
  logic [63:0] imm64, pc64;
  logic [2:0]  fmt32, fmt64;

  int n_tests = 0;
  int n_fail  = 0;

  imm_gen_stage #(.XLEN(32), .RV64(1'b0), .SKID(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_pc(pc32)
  );

  imm_gen_stage #(.XLEN(64), .RV64(1'b1), .SKID(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_pc(pc64)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } txn_t;

  txn_t model_q[$];

  function automatic longint sext(input longint v, input int bits);
    return (v <<< (64 - bits)) >>> (64 - bits);
  endfunction

  // Immediate value as a 64-bit signed number; the 32-bit DUT sees its low half.
  function automatic void ref_decode(input logic [31:0] inst, input bit rv64,
                                     output longint imm, output logic [2:0] fmt);
    imm = 0;
    fmt = FMT_NONE;
    case (inst[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin fmt = FMT_I; imm = sext(inst[31:20], 12); end
      7'h1B: if (rv64) begin fmt = FMT_I; imm = sext(inst[31:20], 12); end
      7'h23: begin fmt = FMT_S; imm = sext({inst[31:25], inst[11:7]}, 12); end
      7'h63: begin fmt = FMT_B; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13); end
      7'h37, 7'h17: begin fmt = FMT_U; imm = sext({inst[31:12], 12'b0}, 32); end
      7'h6F: begin fmt = FMT_J; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21); end
      default: ;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'hFFC10093; in_pc = 64'h1000;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b want 0/0", v32, v64);
    end
    n_tests++;
    if (imm32 !== 32'h0 || imm64 !== 64'h0 || pc32 !== 32'h0 || pc64 !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: imm %h/%h pc %h/%h want zeros", imm32, imm64, pc32, pc64);
    end
    n_tests++;
    if (fmt32 !== FMT_NONE || fmt64 !== FMT_NONE) begin
      n_fail++; $display("FAIL reset_fmt: got %0d/%0d want %0d", fmt32, fmt64, FMT_NONE);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_tests++;
    if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b/%b want 1/1", rdy32, rdy64);
    end
    @(posedge clk); #1;
    n_tests++;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: out_valid %b/%b want 0/0", v32, v64);
    end
  endtask

  task automatic test_formats();
    logic [31:0] insts [8];
    logic [31:0] e32 [8];
    logic [63:0] e64 [8];
    logic [2:0]  f32 [8];
    logic [2:0]  f64 [8];
    insts = '{32'hFFC10093, 32'hFE112E23, 32'hFE000CE3, 32'h004000EF,
              32'h123452B7, 32'h800002B7, 32'h002081B3, 32'h0000001B};
    e32   = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000004,
              32'h12345000, 32'h80000000, 32'h00000000, 32'h00000000};
    e64   = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'h4,
              64'h12345000, 64'hFFFFFFFF80000000, 64'h0, 64'h0};
    f32   = '{FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_U, FMT_NONE, FMT_NONE};
    f64   = '{FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_U, FMT_NONE, FMT_I};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_inst  = insts[i];
      in_pc    = 64'h8000_0000_0000_1000 + 64'(4 * i);
      @(posedge clk); #1;
      n_tests++;
      if (v32 !== 1'b1 || imm32 !== e32[i] || fmt32 !== f32[i] || pc32 !== in_pc[31:0]) begin
        n_fail++;
        $display("FAIL fmt32[%h]: v=%b imm=%h fmt=%0d pc=%h want v=1 imm=%h fmt=%0d pc=%h",
                 insts[i], v32, imm32, fmt32, pc32, e32[i], f32[i], in_pc[31:0]);
      end
      n_tests++;
      if (v64 !== 1'b1 || imm64 !== e64[i] || fmt64 !== f64[i] || pc64 !== in_pc) begin
        n_fail++;
        $display("FAIL fmt64[%h]: v=%b imm=%h fmt=%0d pc=%h want v=1 imm=%h fmt=%0d pc=%h",
                 insts[i], v64, imm64, fmt64, pc64, e64[i], f64[i], in_pc);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin
      n_fail++; $display("FAIL fmt_drain: out_valid %b/%b want 0/0", v32, v64);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] bp [4];
    logic [31:0] want_imm [7];
    logic        want_rdy [7];
    bp = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
    // Outputs after each of 7 edges: 3 stalled clocks, then drain with no bubble.
    want_imm = '{32'd1, 32'd1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    want_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b0; in_valid = 1'b1; in_inst = bp[0]; in_pc = 64'h100;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (c < 6) begin
        if (v32 !== 1'b1 || v64 !== 1'b1 || imm32 !== want_imm[c] || imm64 !== 64'(want_imm[c])
            || pc32 !== 32'h100 + 32'(4 * (want_imm[c] - 1)) || rdy32 !== want_rdy[c] || rdy64 !== want_rdy[c]) begin
          n_fail++;
          $display("FAIL backpressure[%0d]: v=%b imm=%h pc=%h rdy=%b want v=1 imm=%h rdy=%b",
                   c, v32, imm32, pc32, rdy32, want_imm[c], want_rdy[c]);
        end
      end else if (v32 !== 1'b0 || v64 !== 1'b0) begin
        n_fail++; $display("FAIL backpressure_end: out_valid %b/%b want 0/0", v32, v64);
      end
      // Next input only once the current one has been taken.
      case (c)
        0: begin in_inst = bp[1]; in_pc = 64'h104; end
        1: begin in_inst = bp[2]; in_pc = 64'h108; end
        2: out_ready = 1'b1;
        4: begin in_inst = bp[3]; in_pc = 64'h10C; end
        5: in_valid = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_flush();
    // Skid full, flush with input offered.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h200;
    @(posedge clk); #1;
    in_inst = 32'h00600093; in_pc = 64'h204;
    @(posedge clk); #1;
    n_tests++;
    if (rdy32 !== 1'b0 || v32 !== 1'b1) begin
      n_fail++; $display("FAIL flush_setup: in_ready=%b out_valid=%b want 0/1", rdy32, v32);
    end
    flush = 1'b1; out_ready = 1'b1; in_inst = 32'h00700093; in_pc = 64'h208;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (v32 !== 1'b0 || v64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      n_fail++; $display("FAIL flush_full: out_valid %b/%b in_ready %b/%b want 0/0 1/1", v32, v64, rdy32, rdy64);
    end
    @(posedge clk); #1;
    n_tests++;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin
      n_fail++; $display("FAIL flush_drop: out_valid %b/%b want 0/0", v32, v64);
    end
    // Flush while in_ready=1: the same-cycle accept must be discarded too.
    in_valid = 1'b1; in_inst = 32'h00800093; in_pc = 64'h20C; out_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; in_inst = 32'h00900093; in_pc = 64'h210;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (v32 !== 1'b0 || v64 !== 1'b0) begin
      n_fail++; $display("FAIL flush_accept: out_valid %b/%b want 0/0", v32, v64);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h123452B7; in_pc = 64'h300;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++;
    if (v32 !== 1'b1 || imm32 !== 32'h12345000) begin
      n_fail++; $display("FAIL async_setup: v=%b imm=%h want 1/12345000", v32, imm32);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (v32 !== 1'b0 || v64 !== 1'b0 || imm32 !== 32'h0 || fmt64 !== FMT_NONE || pc64 !== 64'h0) begin
      n_fail++; $display("FAIL async_reset: v=%b/%b imm=%h fmt=%0d pc=%h want 0 0 0 0 0", v32, v64, imm32, fmt64, pc64);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (v32 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin
      n_fail++; $display("FAIL async_recover: v=%b rdy=%b/%b want 0 1/1", v32, rdy32, rdy64);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [11];
    logic [31:0] r;
    longint      e32, e64;
    logic [2:0]  f32, f64;
    bit          m_in_rdy, m_out;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h1B, 7'h33};
    model_q.delete();
    for (int c = 0; c < 600; c++) begin
      n_tests++;
      if (v32 !== (model_q.size() > 0) || v64 !== (model_q.size() > 0)
          || rdy32 !== (model_q.size() < 2) || rdy64 !== (model_q.size() < 2)) begin
        n_fail++;
        $display("FAIL rnd_hs[%0d]: v=%b/%b rdy=%b/%b model occupancy %0d", c, v32, v64, rdy32, rdy64, model_q.size());
      end
      if (model_q.size() > 0) begin
        ref_decode(model_q[0].inst, 1'b0, e32, f32);
        ref_decode(model_q[0].inst, 1'b1, e64, f64);
        n_tests++;
        if (imm32 !== e32[31:0] || fmt32 !== f32 || pc32 !== model_q[0].pc[31:0]) begin
          n_fail++;
          $display("FAIL rnd32[%0d] inst=%h: imm=%h fmt=%0d pc=%h want imm=%h fmt=%0d pc=%h",
                   c, model_q[0].inst, imm32, fmt32, pc32, e32[31:0], f32, model_q[0].pc[31:0]);
        end
        n_tests++;
        if (imm64 !== e64 || fmt64 !== f64 || pc64 !== model_q[0].pc) begin
          n_fail++;
          $display("FAIL rnd64[%0d] inst=%h: imm=%h fmt=%0d pc=%h want imm=%h fmt=%0d pc=%h",
                   c, model_q[0].inst, imm64, fmt64, pc64, e64, f64, model_q[0].pc);
        end
      end
      r         = $urandom;
      in_inst   = {r[31:7], ops[$urandom_range(0, 10)]};
      in_pc     = {$urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      m_in_rdy  = (model_q.size() < 2);
      m_out     = (model_q.size() > 0) && out_ready;
      @(posedge clk);
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_out) void'(model_q.pop_front());
        if (in_valid && m_in_rdy) model_q.push_back('{inst: in_inst, pc: in_pc});
      end
      #1;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
